// File: rtl/uart_pkg.sv
// Shared types and helpers for the instruction-memory UART dumper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StSend,
    StNext,
    StDone
  } dump_state_t;

  localparam logic [31:0] TERMINATOR_WORD = 32'hFFFF_FFFF;

  function automatic int unsigned cycles_per_bit(int unsigned clk_hz, int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/imem_uart_dumper_if.sv
// Instruction-memory read port shared between the dumper and the memory.
interface imem_uart_dumper_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; accepts a byte when idle and pulses tx_done in the
// last cycle of the stop bit.
module uart_tx_byte #(
  parameter int unsigned CPB = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int unsigned CntW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(CPB - 1);

  logic            busy_q, busy_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [7:0]      data_q, data_d;
  logic            txd_q, txd_d;
  logic            bit_end;

  always_comb begin
    busy_d  = busy_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    data_d  = data_q;
    txd_d   = txd_q;
    bit_end = busy_q && (baud_q == BaudMax);
    if (!busy_q) begin
      if (tx_valid) begin
        busy_d = 1'b1;
        bit_d  = 4'd0;
        baud_d = '0;
        data_d = tx_data;
        txd_d  = 1'b0;
      end
    end else if (bit_end) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        // Frame bit n+1 carries data bit n; after data bit 7 comes the stop bit.
        txd_d = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      bit_q  <= 4'd0;
      baud_q <= '0;
      data_q <= 8'h00;
      txd_q  <= 1'b1;
    end else begin
      busy_q <= busy_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
      data_q <= data_d;
      txd_q  <= txd_d;
    end
  end

  assign tx_ready = !busy_q;
  assign tx_done  = bit_end && (bit_q == 4'd9);
  assign uart_txd = txd_q;

endmodule

// File: rtl/imem_uart_dumper.sv
// Streams instruction memory from address 0 over UART, four LSB-first bytes per
// word, stopping after the terminator word or NUM_WORDS words.
module imem_uart_dumper
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BIT_RATE  = 9600,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_uart_dumper_if.master  mem,
  output logic                uart_txd,
  output logic                dump_busy,
  output logic                dump_done,
  output logic [ADDR_W:0]     words_sent
);

  localparam int unsigned CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam logic [ADDR_W:0] NumWordsW = (ADDR_W + 1)'(NUM_WORDS);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W:0]   ws_q, ws_d, ws_inc;
  logic              rd_en_q, busy_q, done_q;
  logic              tx_valid, tx_ready, tx_done;
  logic [7:0]        tx_data;

  assign ws_inc = ws_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    idx_d    = idx_q;
    ws_d     = ws_q;
    tx_valid = 1'b0;
    tx_data  = word_q[{idx_q, 3'b000} +: 8];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRd;
          addr_d  = '0;
          ws_d    = '0;
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        // Launch byte 0 straight from the read data so its start bit follows at once.
        word_d   = mem.mem_rd_data;
        idx_d    = 2'd0;
        tx_valid = 1'b1;
        tx_data  = mem.mem_rd_data[7:0];
        state_d  = StSend;
      end
      StSend: begin
        // An idle transmitter while sending always means the current byte is pending.
        tx_valid = tx_ready;
        if (tx_done) begin
          if (idx_q == 2'd3) state_d = StNext;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      StNext: begin
        if (ws_q != NumWordsW) ws_d = ws_inc;
        if (word_q == TERMINATOR_WORD || ws_inc == NumWordsW) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= 32'h0;
      idx_q   <= 2'd0;
      ws_q    <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      ws_q    <= ws_d;
      rd_en_q <= (state_d == StRd);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  uart_tx_byte #(
    .CPB (CPB)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .uart_txd (uart_txd)
  );

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign dump_busy     = busy_q;
  assign dump_done     = done_q;
  assign words_sent    = ws_q;

endmodule

// File: tb/tb_imem_uart_dumper.sv
// Directed bench for imem_uart_dumper at CPB=10 with NUM_WORDS=4.
module tb_imem_uart_dumper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       uart_txd;
  logic       dump_busy;
  logic       dump_done;
  logic [8:0] words_sent;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_words [0:3];

  imem_uart_dumper_if #(.ADDR_W(8)) mif ();

  imem_uart_dumper #(
    .CLK_HZ    (1000),
    .BIT_RATE  (100),
    .ADDR_W    (8),
    .NUM_WORDS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem        (mif),
    .uart_txd   (uart_txd),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dump_done) done_cnt <= done_cnt + 1;
    if (mif.mem_rd_en) mif.mem_rd_data <= mem[mif.mem_addr];
  end

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks idle-high gap before t0, then the full 10-bit frame starting at t0.
  task automatic chk_byte(input int t0, input int gap, input logic [7:0] exp, input string tag);
    logic [9:0] f, m, l;
    logic idle_ok;
    idle_ok = 1'b1;
    for (int g = gap; g >= 1; g--) begin
      wait_cyc(t0 - g);
      idle_ok &= uart_txd;
    end
    for (int i = 0; i < 10; i++) begin
      wait_cyc(t0 + 10 * i);     f[i] = uart_txd;
      wait_cyc(t0 + 10 * i + 5); m[i] = uart_txd;
      wait_cyc(t0 + 10 * i + 9); l[i] = uart_txd;
    end
    chk({tag, "_gap"}, (idle_ok === 1'b1), idle_ok, 1'b1);
    chk({tag, "_startbit"}, (m[0] === 1'b0), m[0], 1'b0);
    chk({tag, "_stopbit"}, (m[9] === 1'b1), m[9], 1'b1);
    chk({tag, "_bitwidth"}, ((f === m) && (m === l)), f, l);
    chk({tag, "_data"}, (m[8:1] === exp), m[8:1], exp);
  endtask

  // Runs a full dump of nwords words from exp_words; poke re-pulses start mid-dump.
  task automatic run_dump(input int nwords, input bit poke, input string tag);
    int t, t0, gap, base, e;
    logic [31:0] ew;
    base = done_cnt;
    pulse_start(t);
    chk({tag, "_rd_en"}, (mif.mem_rd_en === 1'b1), mif.mem_rd_en, 1'b1);
    chk({tag, "_addr0"}, (mif.mem_addr === 8'h00), mif.mem_addr, 8'h00);
    chk({tag, "_busy"}, (dump_busy === 1'b1), dump_busy, 1'b1);
    for (int w = 0; w < nwords; w++) begin
      ew = exp_words[w];
      for (int k = 0; k < 4; k++) begin
        t0  = t + 3 + w * 406 + k * 101;
        gap = (k != 0) ? 1 : ((w == 0) ? 2 : 3);
        chk_byte(t0, gap, ew[8 * k +: 8], $sformatf("%s_w%0d_b%0d", tag, w, k));
        if (poke && w == 0 && k == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    e = t + 3 + (nwords - 1) * 406 + 303 + 99;
    wait_cyc(e + 1);
    chk({tag, "_done_early"}, (dump_done === 1'b0), dump_done, 1'b0);
    wait_cyc(e + 2);
    chk({tag, "_done_pulse"}, (dump_done === 1'b1), dump_done, 1'b1);
    wait_cyc(e + 3);
    chk({tag, "_done_count"}, ((done_cnt - base) === 1), done_cnt - base, 1);
    chk({tag, "_busy_end"}, (dump_busy === 1'b0), dump_busy, 1'b0);
    chk({tag, "_words_sent"}, (words_sent === 9'(nwords)), words_sent, nwords);
  endtask

  initial begin
    int t, t0, base;
    logic rd_any, busy_any, txd_all;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_txd", (uart_txd === 1'b1), uart_txd, 1'b1);
    chk("rst_rd_en", (mif.mem_rd_en === 1'b0), mif.mem_rd_en, 1'b0);
    chk("rst_addr", (mif.mem_addr === 8'h00), mif.mem_addr, 8'h00);
    chk("rst_busy", (dump_busy === 1'b0), dump_busy, 1'b0);
    chk("rst_done", (dump_done === 1'b0), dump_done, 1'b0);
    chk("rst_words", (words_sent === 9'd0), words_sent, 9'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two words ending in the terminator.
    mem[0] = 32'h04812E23;
    mem[1] = 32'hFFFFFFFF;
    exp_words[0] = 32'h04812E23;
    exp_words[1] = 32'hFFFFFFFF;
    run_dump(2, 1'b0, "term");
    repeat (5) @(negedge clk);

    // No terminator: stops at NUM_WORDS=4, word 4 must never go out.
    mem[0] = 32'h11223344;
    mem[1] = 32'hA5A5005A;
    mem[2] = 32'h00000000;
    mem[3] = 32'hDEADBEEF;
    mem[4] = 32'h12345678;
    exp_words[0] = 32'h11223344;
    exp_words[1] = 32'hA5A5005A;
    exp_words[2] = 32'h00000000;
    exp_words[3] = 32'hDEADBEEF;
    run_dump(4, 1'b0, "max");
    rd_any = 1'b0;
    txd_all = 1'b1;
    repeat (40) begin
      @(negedge clk);
      rd_any |= mif.mem_rd_en;
      txd_all &= uart_txd;
    end
    chk("max_no_extra_rd", (rd_any === 1'b0), rd_any, 1'b0);
    chk("max_no_extra_tx", (txd_all === 1'b1), txd_all, 1'b1);

    // Extra start mid-dump is ignored.
    mem[0] = 32'h04812E23;
    mem[1] = 32'hFFFFFFFF;
    exp_words[0] = 32'h04812E23;
    exp_words[1] = 32'hFFFFFFFF;
    run_dump(2, 1'b1, "poke");
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of byte 1 (0x2E, bit 3 = 1).
    base = done_cnt;
    pulse_start(t);
    chk_byte(t + 3, 2, 8'h23, "rst_b0");
    t0 = t + 3 + 101;
    wait_cyc(t0 + 15);
    chk("rst_b1_bit0", (uart_txd === 1'b0), uart_txd, 1'b0);
    wait_cyc(t0 + 44);
    chk("rst_b1_bit3", (uart_txd === 1'b1), uart_txd, 1'b1);
    chk("rst_b1_busy", (dump_busy === 1'b1), dump_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_txd", (uart_txd === 1'b1), uart_txd, 1'b1);
    chk("midrst_busy", (dump_busy === 1'b0), dump_busy, 1'b0);
    chk("midrst_rd_en", (mif.mem_rd_en === 1'b0), mif.mem_rd_en, 1'b0);
    chk("midrst_words", (words_sent === 9'd0), words_sent, 9'd0);
    txd_all = 1'b1;
    repeat (500) begin
      @(negedge clk);
      txd_all &= uart_txd;
    end
    chk("midrst_idle_txd", (txd_all === 1'b1), txd_all, 1'b1);
    chk("midrst_no_done", ((done_cnt - base) === 0), done_cnt - base, 0);
    run_dump(2, 1'b0, "restart");
    repeat (5) @(negedge clk);

    // rst and start together: rst wins.
    base = done_cnt;
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    rd_any = 1'b0;
    busy_any = 1'b0;
    txd_all = 1'b1;
    repeat (30) begin
      @(negedge clk);
      rd_any |= mif.mem_rd_en;
      busy_any |= dump_busy;
      txd_all &= uart_txd;
    end
    chk("rststart_rd_en", (rd_any === 1'b0), rd_any, 1'b0);
    chk("rststart_busy", (busy_any === 1'b0), busy_any, 1'b0);
    chk("rststart_txd", (txd_all === 1'b1), txd_all, 1'b1);
    chk("rststart_done", ((done_cnt - base) === 0), done_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
